// File: rtl/axis_frame_packer_pkg.sv
// Shared types and limits for the frame packer: FSM state encoding and
// the legal range of channels per frame.
package frame_packer_pkg;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    HOLD   = 2'd1,
    RESYNC = 2'd2
  } state_e;

  localparam int CHANNELS_MIN = 2;
  localparam int CHANNELS_MAX = 16;

endpackage

// File: rtl/axis_frame_packer_if.sv
// Valid/ready stream bundle. It is used for the serial sample side and for
// the packed frame side; last is meaningful on the sample side only.
interface axis_frame_packer_if #(
  parameter int W = 24
);
  logic [W-1:0] data;
  logic         valid;
  logic         last;
  logic         ready;

  modport master (output data, output valid, output last, input  ready);
  modport slave  (input  data, input  valid, input  last, output ready);
endinterface

// File: rtl/axis_frame_packer_core.sv
// Packer datapath and FILL/HOLD/RESYNC control. The error counter exists
// only when FRAME_PACKER_ERR_CNT_EN is defined; otherwise the count reads 0.
module axis_frame_packer_core
  import frame_packer_pkg::*;
#(
  parameter int W   = 24,
  parameter int CH  = 2,
  parameter int ECW = 8
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  axis_frame_packer_if.slave   s_bus,
  axis_frame_packer_if.master  m_bus,
  output logic                 err_o,
  output logic [ECW-1:0]       err_count_o
);

  localparam int                IDX_W    = $clog2(CH);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(CH - 1);

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [CH-1:0][W-1:0]   slot_q;
  logic                   err_d;
  logic                   s_fire;
  logic                   m_fire;

  // Ready is gated by reset so it reads 0 while reset is held.
  assign s_bus.ready = ~reset_i & (state_q != HOLD);
  assign s_fire      = s_bus.valid & s_bus.ready;
  assign m_bus.valid = (state_q == HOLD);
  assign m_bus.data  = slot_q;
  assign m_bus.last  = 1'b1;
  assign m_fire      = m_bus.valid & m_bus.ready;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= FILL;
      idx_q   <= '0;
      err_o   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_o   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    err_d   = 1'b0;
    case (state_q)
      FILL: begin
        if (s_fire) begin
          if (s_bus.last) begin
            // Last on the final slot completes the frame; earlier is a short frame.
            if (idx_q == IDX_LAST) state_d = HOLD;
            else                   err_d   = 1'b1;
            idx_d = '0;
          end else if (idx_q == IDX_LAST) begin
            err_d   = 1'b1;
            state_d = RESYNC;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      HOLD: begin
        if (m_fire) begin
          state_d = FILL;
          idx_d   = '0;
        end
      end
      RESYNC: begin
        if (s_fire && s_bus.last) begin
          state_d = FILL;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = FILL;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)                        slot_q        <= '0;
    else if (state_q == FILL && s_fire) slot_q[idx_q] <= s_bus.data;
  end

`ifdef FRAME_PACKER_ERR_CNT_EN
  // Counts on the same event that launches err_o, so the count and pulse line up.
  frame_err_counter #(.W(ECW)) u_err_cnt (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .inc_i   (err_d),
    .count_o (err_count_o)
  );
`else
  assign err_count_o = '0;
`endif

endmodule

// File: rtl/frame_err_counter.sv
// Saturating event counter. It sticks at all-ones and never wraps.
module frame_err_counter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)                     count_o <= '0;
    else if (inc_i && (count_o != '1)) count_o <= count_o + 1'b1;
  end

endmodule

// File: rtl/axis_frame_packer.sv
// Packs CHANNELS_P serial samples into one frame, channel 0 in the LSBs.
// Optional saturating framing-error counter: define FRAME_PACKER_ERR_CNT_EN.
module axis_frame_packer
  import frame_packer_pkg::*;
#(
  parameter int WIDTH_P     = 24,
  parameter int CHANNELS_P  = 2,
  parameter int ERR_CNT_W_P = 8
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [WIDTH_P-1:0]            s_data_i,
  input  logic                          s_valid_i,
  input  logic                          s_last_i,
  output logic                          s_ready_o,
  output logic [CHANNELS_P*WIDTH_P-1:0] m_data_o,
  output logic                          m_valid_o,
  input  logic                          m_ready_i,
  output logic                          err_o,
  output logic [ERR_CNT_W_P-1:0]        err_count_o
);

  axis_frame_packer_if #(.W(WIDTH_P))            s_if ();
  axis_frame_packer_if #(.W(CHANNELS_P*WIDTH_P)) m_if ();

  assign s_if.data  = s_data_i;
  assign s_if.valid = s_valid_i;
  assign s_if.last  = s_last_i;
  assign s_ready_o  = s_if.ready;

  assign m_data_o   = m_if.data;
  assign m_valid_o  = m_if.valid;
  assign m_if.ready = m_ready_i;

  axis_frame_packer_core #(
    .W   (WIDTH_P),
    .CH  (CHANNELS_P),
    .ECW (ERR_CNT_W_P)
  ) u_core (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .s_bus       (s_if.slave),
    .m_bus       (m_if.master),
    .err_o       (err_o),
    .err_count_o (err_count_o)
  );

endmodule

// File: tb/tb_axis_frame_packer.sv
// Directed bench for axis_frame_packer: a 2-channel 24-bit instance and a
// 4-channel 4-bit instance with a 2-bit error counter, scoreboard checked.
module tb_axis_frame_packer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axis_frame_packer_if #(.W(24)) s2 ();
  axis_frame_packer_if #(.W(4))  s4 ();

  logic [47:0] m2_data;
  logic        m2_valid, m2_ready;
  logic        err2;
  logic [7:0]  cnt2;
  logic [15:0] m4_data;
  logic        m4_valid, m4_ready;
  logic        err4;
  logic [1:0]  cnt4;

  axis_frame_packer #(.WIDTH_P(24), .CHANNELS_P(2), .ERR_CNT_W_P(8)) dut2 (
    .clk_i(clk), .reset_i(rst),
    .s_data_i(s2.data), .s_valid_i(s2.valid), .s_last_i(s2.last), .s_ready_o(s2.ready),
    .m_data_o(m2_data), .m_valid_o(m2_valid), .m_ready_i(m2_ready),
    .err_o(err2), .err_count_o(cnt2)
  );

  axis_frame_packer #(.WIDTH_P(4), .CHANNELS_P(4), .ERR_CNT_W_P(2)) dut4 (
    .clk_i(clk), .reset_i(rst),
    .s_data_i(s4.data), .s_valid_i(s4.valid), .s_last_i(s4.last), .s_ready_o(s4.ready),
    .m_data_o(m4_data), .m_valid_o(m4_valid), .m_ready_i(m4_ready),
    .err_o(err4), .err_count_o(cnt4)
  );

  int chk   = 0;
  int fails = 0;

  logic [47:0] fq2[$];
  logic [15:0] fq4[$];
  int          eq2[$];
  int          eq4[$];
  int          e2 = 0;
  int          e4 = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    chk++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Expected counter value after n errors on a counter of width w.
  function automatic int sat(input int n, input int w);
`ifdef FRAME_PACKER_ERR_CNT_EN
    int mx;
    mx = (1 << w) - 1;
    return (n > mx) ? mx : n;
`else
    return 0;
`endif
  endfunction

  // Monitor: pops expectations whenever a frame or an error pulse appears.
  always @(negedge clk) begin
    if (!rst) begin
      if (m2_valid && m2_ready) begin
        if (fq2.size() == 0) check("frame2_unexpected", {16'h0, m2_data}, 64'hDEAD);
        else check("frame2", {16'h0, m2_data}, {16'h0, fq2.pop_front()});
      end
      if (m4_valid && m4_ready) begin
        if (fq4.size() == 0) check("frame4_unexpected", {48'h0, m4_data}, 64'hDEAD);
        else check("frame4", {48'h0, m4_data}, {48'h0, fq4.pop_front()});
      end
      if (err2) begin
        if (eq2.size() == 0) check("err2_unexpected", 64'(cnt2), 64'hDEAD);
        else check("err2_count", 64'(cnt2), 64'(eq2.pop_front()));
      end
      if (err4) begin
        if (eq4.size() == 0) check("err4_unexpected", 64'(cnt4), 64'hDEAD);
        else check("err4_count", 64'(cnt4), 64'(eq4.pop_front()));
      end
    end
  end

  task automatic send2(input logic [23:0] d, input logic l);
    int n = 0;
    s2.data = d; s2.last = l; s2.valid = 1'b1;
    @(negedge clk);
    while (!s2.ready && n < 50) begin @(negedge clk); n++; end
    if (!s2.ready) check("send2_timeout", 64'(s2.ready), 64'h1);
    @(posedge clk); #1;
    s2.valid = 1'b0;
  endtask

  task automatic send4(input logic [3:0] d, input logic l);
    int n = 0;
    s4.data = d; s4.last = l; s4.valid = 1'b1;
    @(negedge clk);
    while (!s4.ready && n < 50) begin @(negedge clk); n++; end
    if (!s4.ready) check("send4_timeout", 64'(s4.ready), 64'h1);
    @(posedge clk); #1;
    s4.valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    e2 = 0; e4 = 0;
    @(posedge clk); #1;
    check("rst_s_ready2", 64'(s2.ready), 64'h0);
    check("rst_s_ready4", 64'(s4.ready), 64'h0);
    check("rst_m_valid2", 64'(m2_valid), 64'h0);
    check("rst_m_data2",  {16'h0, m2_data}, 64'h0);
    check("rst_err2",     64'(err2), 64'h0);
    check("rst_cnt4",     64'(cnt4), 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("post_rst_s_ready2", 64'(s2.ready), 64'h1);
    check("post_rst_s_ready4", 64'(s4.ready), 64'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    s2.data = '0; s2.valid = 1'b0; s2.last = 1'b0;
    s4.data = '0; s4.valid = 1'b0; s4.last = 1'b0;
    m2_ready = 1'b1; m4_ready = 1'b1;
    #3;
    do_reset();

    // Basic 2-channel frame with one-cycle output latency.
    fq2.push_back(48'h000222_000111);
    send2(24'h000111, 1'b0);
    check("A_valid_after_beat0", 64'(m2_valid), 64'h0);
    send2(24'h000222, 1'b1);
    check("A_valid_after_beat1", 64'(m2_valid), 64'h1);
    @(posedge clk); #1;
    check("A_valid_dropped", 64'(m2_valid), 64'h0);

    // Short first frame on the 4-channel instance, then a good frame.
    e4++; eq4.push_back(sat(e4, 2));
    send4(4'hA, 1'b1);
    fq4.push_back(16'h4321);
    send4(4'h1, 1'b0); send4(4'h2, 1'b0); send4(4'h3, 1'b0); send4(4'h4, 1'b1);
    @(posedge clk); #1;
    check("B_cnt4", 64'(cnt4), 64'(sat(1, 2)));

    // Long frame forces resync; the following pair still packs.
    send2(24'h1, 1'b0);
    e2++; eq2.push_back(sat(e2, 8));
    send2(24'h2, 1'b0);
    send2(24'h3, 1'b0);
    send2(24'h4, 1'b1);
    check("C_no_frame", 64'(m2_valid), 64'h0);
    fq2.push_back(48'h000008_000007);
    send2(24'h7, 1'b0); send2(24'h8, 1'b1);
    @(posedge clk); #1;
    check("C_cnt2", 64'(cnt2), 64'(sat(1, 8)));

    // Backpressure: frame held stable for 10 cycles.
    m2_ready = 1'b0;
    send2(24'hABCDEF, 1'b0); send2(24'h123456, 1'b1);
    s2.data = 24'h55; s2.last = 1'b1; s2.valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("D_hold_valid", 64'(m2_valid), 64'h1);
      check("D_hold_ready", 64'(s2.ready), 64'h0);
      check("D_hold_data",  {16'h0, m2_data}, 64'h123456_ABCDEF);
    end
    @(posedge clk); #1;
    s2.valid = 1'b0;
    fq2.push_back(48'h123456_ABCDEF);
    m2_ready = 1'b1;
    @(posedge clk); #1;
    check("D_released", 64'(m2_valid), 64'h0);
    check("D_ready_back", 64'(s2.ready), 64'h1);

    // Saturating 2-bit counter across five short frames.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      e4++; eq4.push_back(sat(e4, 2));
      send4(4'(i), 1'b1);
    end
    @(posedge clk); #1;
    check("E_cnt4_final", 64'(cnt4), 64'(sat(5, 2)));

    // Reset mid-frame discards the partial frame.
    send2(24'h9, 1'b0);
    rst = 1'b1;
    e2 = 0; e4 = 0;
    @(posedge clk); #1;
    check("F_rst_valid", 64'(m2_valid), 64'h0);
    check("F_rst_cnt4",  64'(cnt4), 64'h0);
    rst = 1'b0;
    #1;
    check("F_post_rst_ready", 64'(s2.ready), 64'h1);
    fq2.push_back(48'h000006_000005);
    send2(24'h5, 1'b0); send2(24'h6, 1'b1);

    repeat (5) @(posedge clk);
    #1;
    check("end_fq2_empty", 64'(fq2.size()), 64'h0);
    check("end_fq4_empty", 64'(fq4.size()), 64'h0);
    check("end_eq2_empty", 64'(eq2.size()), 64'h0);
    check("end_eq4_empty", 64'(eq4.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", chk, fails);
    $finish;
  end

endmodule

// File: doc/axis_frame_packer.md
AXIS_FRAME_PACKER -- requirements
Module: axis_frame_packer

Interface
REQ-001 SHALL have parameter WIDTH_P, default 24, meaning bits per channel sample.
REQ-002 SHALL have parameter CHANNELS_P, default 2, meaning samples per frame; legal range is 2..16.
REQ-003 SHALL have parameter ERR_CNT_W_P, default 8, meaning framing-error counter width.
REQ-004 SHALL have port clk_i, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset_i, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port s_data_i, input, WIDTH_P, the serial sample.
REQ-007 SHALL have port s_valid_i, input, 1, sample valid.
REQ-008 SHALL have port s_last_i, input, 1, marking the final channel of a frame.
REQ-009 SHALL have port s_ready_o, output, 1, sample accept.
REQ-010 SHALL have port m_data_o, output, CHANNELS_P*WIDTH_P, the packed frame; channel 0 occupies the LSBs.
REQ-011 SHALL have port m_valid_o, output, 1, frame valid.
REQ-012 SHALL have port m_ready_i, input, 1, frame accept.
REQ-013 SHALL have port err_o, output, 1, a one-cycle framing-error pulse.
REQ-014 SHALL have port err_count_o, output, ERR_CNT_W_P, the saturating error count.

Function
REQ-015 SHALL transfer a beat only when s_valid_i and s_ready_o are both 1, and a frame only when m_valid_o and m_ready_i are both 1.
REQ-016 SHALL implement exactly three states: FILL, HOLD and RESYNC, with a channel index idx in the range 0..CHANNELS_P-1.
REQ-017 In FILL, SHALL drive s_ready_o=1 and m_valid_o=0, and SHALL write each accepted beat into slot idx.
REQ-018 In FILL, an accepted beat with idx<CHANNELS_P-1 and s_last_i=0 SHALL increment idx.
REQ-019 In FILL, an accepted beat with idx==CHANNELS_P-1 and s_last_i=1 SHALL move the block to HOLD, and m_valid_o SHALL assert on the next cycle (one-cycle latency).
REQ-020 In FILL, an accepted beat with idx<CHANNELS_P-1 and s_last_i=1 (short frame) SHALL discard the partial frame, pulse err_o, reset idx to 0 and stay in FILL.
REQ-021 In FILL, an accepted beat with idx==CHANNELS_P-1 and s_last_i=0 (long frame) SHALL discard the frame, pulse err_o and move the block to RESYNC.
REQ-022 In RESYNC, SHALL drive s_ready_o=1 and drop beats until one arrives with s_last_i=1; that beat is also dropped, and the block then enters FILL with idx=0.
REQ-023 In HOLD, SHALL drive s_ready_o=0 and m_valid_o=1; m_data_o SHALL remain stable until the frame handshake, after which the block enters FILL with idx=0.
REQ-024 m_valid_o, once asserted, SHALL NOT deassert before the frame handshake.
REQ-025 err_o SHALL be registered, asserting the cycle after the offending beat for exactly one cycle.
REQ-026 Each err_o pulse SHALL increment err_count_o, which saturates at all-ones and does not wrap.
REQ-027 Sustained throughput SHALL be one frame per CHANNELS_P+1 cycles.

Reset
REQ-028 While reset_i=1, SHALL force state=FILL, idx=0, m_valid_o=0, err_o=0, err_count_o=0 and m_data_o=0, and s_ready_o SHALL read 0.
REQ-029 Assertion of reset_i mid-frame or in HOLD SHALL discard all buffered data with no further handshakes.
REQ-030 s_ready_o SHALL be 1 in the first cycle after reset_i deasserts.

Configuration
REQ-031 With FRAME_PACKER_ERR_CNT_EN defined, the err_count_o counter SHALL be present as specified.
REQ-032 Without FRAME_PACKER_ERR_CNT_EN, err_count_o SHALL be tied to 0 and no counter flops SHALL be inferred; err_o and resync behaviour SHALL be unchanged.

Structure
REQ-033 Package frame_packer_pkg SHALL hold the state enum typedef (FILL, HOLD, RESYNC) and the CHANNELS_P legality bounds.
REQ-034 One sub-module, frame_err_counter (a saturating counter), is natural and SHALL be instantiated under the macro.

Verification
REQ-035 The bench SHALL cover: with CHANNELS_P=2 and WIDTH_P=24, beats 0x000111 then 0x000222 (last=1) and m_ready_i=1 -> m_data_o=0x000222_000111, with m_valid_o asserting 1 cycle after the second beat.
REQ-036 The bench SHALL cover: with CHANNELS_P=4, beat 0xA with last=1 as the first beat -> err_o pulse, err_count_o=1, no frame; the next 4 beats 1,2,3,4 (last on 4) -> frame 0x4_3_2_1 in slots.
REQ-037 The bench SHALL cover: with CHANNELS_P=2, 3 beats without last, then a beat with last -> err_o once, no frame; a following well-formed pair -> exactly one frame.
REQ-038 The bench SHALL cover: a frame held while m_ready_i=0 for 10 cycles -> m_data_o stable, s_ready_o=0 throughout, and the frame released on the cycle m_ready_i=1.
REQ-039 The bench SHALL cover: with ERR_CNT_W_P=2, 5 short frames -> err_count_o sequence 1,2,3,3,3; without the macro -> err_count_o=0 throughout.
REQ-040 The bench SHALL cover: reset_i asserted after 1 beat of a 2-channel frame -> no m_valid_o; post-reset beats 5 and 6 (last) -> frame {6,5}.
